// File: rtl/matrix_unit_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and one shared scale_matrix unit.
// 'slave' is the arbiter's view; 'master' is the requester/math-unit side.
interface matrix_unit_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*256-1:0] req_matrix;
    logic [NUM_REQ*8-1:0]   req_scalar;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [255:0]           rsp_matrix;
    logic                   unit_enable;
    logic [255:0]           unit_matrix;
    logic [7:0]             unit_scalar;
    logic [255:0]           unit_m_out;
    logic                   unit_done;
    logic                   busy;
    logic                   timeout_err;

    modport slave (
        input  req, req_matrix, req_scalar, unit_m_out, unit_done,
        output gnt, rsp_valid, rsp_matrix, unit_enable, unit_matrix, unit_scalar,
               busy, timeout_err
    );

    modport master (
        output req, req_matrix, req_scalar, unit_m_out, unit_done,
        input  gnt, rsp_valid, rsp_matrix, unit_enable, unit_matrix, unit_scalar,
               busy, timeout_err
    );
endinterface

// File: rtl/matrix_unit_arbiter.sv
// Round-robin share of one scale_matrix unit among NUM_REQ requesters.
// One operation at a time: IDLE -> GRANT -> ISSUE -> WAIT -> RESP, all outputs registered.
module matrix_unit_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    matrix_unit_arbiter_if.slave  bus
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    state_e             state_q;
    logic [OWN_W-1:0]   last_owner_q;
    logic [OWN_W-1:0]   owner_q;
    logic [255:0]       opm_q;
    logic [7:0]         ops_q;
    logic [7:0]         cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [255:0]       rsp_q;
    logic               unit_enable_q;
    logic               busy_q;
    logic               timeout_err_q;

    logic [OWN_W-1:0]   pick_d;
    logic [NUM_REQ-1:0] pick_oh_d;
    logic               pick_vld_d;
    logic [NUM_REQ-1:0] own_oh_d;

    // Walk from the lowest-priority slot (last_owner) down to the highest
    // (last_owner+1) so the final hit is the round-robin winner.
    always_comb begin
        pick_d     = '0;
        pick_oh_d  = '0;
        pick_vld_d = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(last_owner_q) + k) % NUM_REQ]) begin
                pick_d     = OWN_W'((int'(last_owner_q) + k) % NUM_REQ);
                pick_oh_d  = '0;
                pick_oh_d[(int'(last_owner_q) + k) % NUM_REQ] = 1'b1;
                pick_vld_d = 1'b1;
            end
        end
    end

    always_comb begin
        own_oh_d          = '0;
        own_oh_d[owner_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_owner_q  <= OWN_W'(NUM_REQ - 1);
            owner_q       <= '0;
            opm_q         <= '0;
            ops_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_q         <= '0;
            unit_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            unit_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        owner_q <= pick_d;
                        opm_q   <= bus.req_matrix[int'(pick_d)*256 +: 256];
                        ops_q   <= bus.req_scalar[int'(pick_d)*8 +: 8];
                        gnt_q   <= pick_oh_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    unit_enable_q <= 1'b1;
                    state_q       <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // The unit answers on the edge that sampled enable, so done may already be up here.
                    if (bus.unit_done) begin
                        rsp_q       <= bus.unit_m_out;
                        rsp_valid_q <= own_oh_d;
                        state_q     <= RESP;
                    end else if ({1'b0, cnt_q} + 9'd1 == 9'(TIMEOUT)) begin
                        timeout_err_q <= 1'b1;
                        rsp_q         <= '0;
                        rsp_valid_q   <= own_oh_d;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    last_owner_q <= owner_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_matrix  = rsp_q;
    assign bus.unit_enable = unit_enable_q;
    assign bus.unit_matrix = opm_q;
    assign bus.unit_scalar = ops_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
